// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane mask helper used by the SRAM bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic       HRESP_OKAY = 1'b0;

  // Sizes above a word are treated as a full word.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] mask;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = 4'b0011 << {addr[1], 1'b0};
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_bridge_if.sv
// AHB-Lite slave-side bus signals for the SRAM bridge.
interface ahb_sram_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/sram_wbuf.sv
// One-entry write buffer with read-data merge for the AHB SRAM bridge.
module sram_wbuf #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              drain,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [3:0]        cap_lanes,
  input  logic [31:0]       cap_data,
  input  logic              rd_pend,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       ram_q,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        wb_lanes,
  output logic [31:0]       wb_data,
  output logic [31:0]       rdata
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        lanes_q;
  logic [31:0]       data_q;
  logic              hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= cap_addr;
      lanes_q <= cap_lanes;
      data_q  <= cap_data;
    end
  end

  assign hit = rd_pend & valid_q & (addr_q == rd_addr);

  // Buffered bytes are newer than the SRAM copy, so they win lane by lane.
  always_comb begin
    rdata = ram_q;
    for (int i = 0; i < 4; i++) begin
      if (hit && lanes_q[i]) begin
        rdata[8*i +: 8] = data_q[8*i +: 8];
      end
    end
  end

  assign wb_valid = valid_q;
  assign wb_addr  = addr_q;
  assign wb_lanes = lanes_q;
  assign wb_data  = data_q;

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite slave driving a single-port SRAM; reads take the port first and
// a colliding write is parked in a one-entry buffer until the port is free.
module ahb_sram_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_sram_bridge_if.slave  ahb,
  output logic [ADDR_W-1:0] ram_a,
  output logic [31:0]       ram_d,
  output logic              ram_cen,
  output logic [3:0]        ram_wen,
  input  logic [31:0]       ram_q
);

  logic              acc, rd_acc, wr_acc;
  logic [ADDR_W-1:0] haddr_word;
  logic              dp_wr_q;
  logic [ADDR_W-1:0] dp_addr_q;
  logic [3:0]        dp_lanes_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [3:0]        wb_lanes;
  logic [31:0]       wb_data;
  logic              capture, drain;
  logic              unused_bits;

  assign acc        = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign rd_acc     = acc & ~ahb.HWRITE;
  assign wr_acc     = acc & ahb.HWRITE;
  assign haddr_word = ahb.HADDR[ADDR_W+1:2];
  assign unused_bits = ^{ahb.HADDR[31:ADDR_W+2], ahb.HTRANS[0]};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_wr_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      dp_wr_q   <= wr_acc;
      rd_pend_q <= rd_acc;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_acc) begin
      dp_addr_q  <= haddr_word;
      dp_lanes_q <= lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
    end
    if (rd_acc) begin
      rd_addr_q <= haddr_word;
    end
  end

  // A data-phase write loses the port to a read and is parked; otherwise the buffer drains.
  assign capture = rd_acc & dp_wr_q;
  assign drain   = ~rd_acc & wb_valid;

  sram_wbuf #(
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .capture   (capture),
    .drain     (drain),
    .cap_addr  (dp_addr_q),
    .cap_lanes (dp_lanes_q),
    .cap_data  (ahb.HWDATA),
    .rd_pend   (rd_pend_q),
    .rd_addr   (rd_addr_q),
    .ram_q     (ram_q),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_lanes  (wb_lanes),
    .wb_data   (wb_data),
    .rdata     (ahb.HRDATA)
  );

  always_comb begin
    ram_cen = 1'b0;
    ram_wen = 4'b0000;
    ram_a   = haddr_word;
    ram_d   = ahb.HWDATA;
    if (!HRESETn) begin
      ram_cen = 1'b0;
    end else if (rd_acc) begin
      ram_cen = 1'b1;
    end else if (wb_valid) begin
      ram_cen = 1'b1;
      ram_a   = wb_addr;
      ram_d   = wb_data;
      ram_wen = wb_lanes;
    end else if (dp_wr_q) begin
      ram_cen = 1'b1;
      ram_a   = dp_addr_q;
      ram_wen = dp_lanes_q;
    end
  end

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed self-checking bench for ahb_sram_bridge with a behavioural registered-read SRAM.
module tb_ahb_sram_bridge;
  import ahb_pkg::*;

  localparam int unsigned ADDR_W = 13;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_d;
  logic              ram_cen;
  logic [3:0]        ram_wen;
  logic [31:0]       ram_q;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_a;
  logic [31:0]       pl_d;
  int                wr_count = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  ahb_sram_bridge_if bus ();

  ahb_sram_bridge #(
    .ADDR_W (ADDR_W)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_cen (ram_cen),
    .ram_wen (ram_wen),
    .ram_q   (ram_q)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (ram_cen) begin
      if (ram_wen != 4'b0000) begin
        wr_count <= wr_count + 1;
        for (int i = 0; i < 4; i++) begin
          if (ram_wen[i]) mem[ram_a][8*i +: 8] <= ram_d[8*i +: 8];
        end
      end else begin
        ram_q <= mem[ram_a];
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HREADY = 1'b1;
  endtask

  task automatic drive_idle();
    drive(1'b0, TransIdle, 1'b0, 32'h0, HSIZE_WORD);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    drive_idle();
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn    = 1'b0;
    bus.HWDATA = 32'h0;
    drive_idle();
    step();
    drive(1'b1, TransNonseq, 1'b0, 32'h10, HSIZE_WORD);
    #1;
    n_cmp++;
    if (ram_cen !== 1'b0) begin
      n_err++; $display("FAIL reset_cen: got %b want 0", ram_cen);
    end
    n_cmp++;
    if (ram_wen !== 4'b0000) begin
      n_err++; $display("FAIL reset_wen: got %b want 0000", ram_wen);
    end
    n_cmp++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
      n_err++; $display("FAIL reset_resp: got rdy=%b resp=%b want 1/0", bus.HREADYOUT, bus.HRESP);
    end
    step();
    drive_idle();
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_read();
    preload(13'd4, 32'hDEADBEEF);
    drive(1'b1, TransNonseq, 1'b0, 32'h10, HSIZE_WORD);
    #1;
    n_cmp++;
    if (ram_cen !== 1'b1 || ram_wen !== 4'b0000 || ram_a !== 13'd4) begin
      n_err++; $display("FAIL read_addr: got cen=%b wen=%b a=%h want 1/0000/004",
                        ram_cen, ram_wen, ram_a);
    end
    step();
    drive_idle();
    #1;
    n_cmp++;
    if (bus.HRDATA !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL read_data: got %h want deadbeef", bus.HRDATA);
    end
    n_cmp++;
    if (bus.HREADYOUT !== 1'b1) begin
      n_err++; $display("FAIL read_ready: got %b want 1", bus.HREADYOUT);
    end
    step();
  endtask

  task automatic test_word_write();
    drive(1'b1, TransNonseq, 1'b1, 32'h20, HSIZE_WORD);
    step();
    drive_idle();
    bus.HWDATA = 32'h11223344;
    #1;
    n_cmp++;
    if (ram_wen !== 4'hF || ram_a !== 13'd8 || ram_d !== 32'h11223344 || ram_cen !== 1'b1) begin
      n_err++; $display("FAIL word_write: got wen=%h a=%h d=%h want f/008/11223344",
                        ram_wen, ram_a, ram_d);
    end
    step();
    n_cmp++;
    if (mem[8] !== 32'h11223344) begin
      n_err++; $display("FAIL word_write_mem: got %h want 11223344", mem[8]);
    end
  endtask

  task automatic test_partial_write();
    drive(1'b1, TransNonseq, 1'b1, 32'h21, HSIZE_BYTE);
    step();
    drive(1'b1, TransNonseq, 1'b1, 32'h22, HSIZE_HALF);
    bus.HWDATA = 32'h0000AA00;
    #1;
    n_cmp++;
    if (ram_wen !== 4'b0010) begin
      n_err++; $display("FAIL byte_lanes: got %b want 0010", ram_wen);
    end
    step();
    drive_idle();
    bus.HWDATA = 32'hBBCC0000;
    #1;
    n_cmp++;
    if (ram_wen !== 4'b1100) begin
      n_err++; $display("FAIL half_lanes: got %b want 1100", ram_wen);
    end
    step();
    drive(1'b1, TransNonseq, 1'b0, 32'h20, HSIZE_WORD);
    step();
    drive_idle();
    #1;
    n_cmp++;
    if (bus.HRDATA !== 32'hBBCCAA44) begin
      n_err++; $display("FAIL partial_read: got %h want bbccaa44", bus.HRDATA);
    end
    step();
  endtask

  task automatic test_write_read();
    drive(1'b1, TransNonseq, 1'b1, 32'h40, HSIZE_WORD);
    step();
    drive(1'b1, TransNonseq, 1'b0, 32'h40, HSIZE_WORD);
    bus.HWDATA = 32'hCAFEF00D;
    #1;
    n_cmp++;
    if (ram_cen !== 1'b1 || ram_wen !== 4'b0000 || ram_a !== 13'h10) begin
      n_err++; $display("FAIL wr_rd_addr: got cen=%b wen=%b a=%h want 1/0000/010",
                        ram_cen, ram_wen, ram_a);
    end
    step();
    drive_idle();
    bus.HWDATA = 32'h0;
    #1;
    n_cmp++;
    if (bus.HRDATA !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL wr_rd_merge: got %h want cafef00d", bus.HRDATA);
    end
    n_cmp++;
    if (ram_wen !== 4'hF || ram_a !== 13'h10 || ram_d !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL wr_rd_drain: got wen=%h a=%h d=%h want f/010/cafef00d",
                        ram_wen, ram_a, ram_d);
    end
    step();
    n_cmp++;
    if (mem[16] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL wr_rd_mem: got %h want cafef00d", mem[16]);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    preload(13'd16, 32'h0);
    w0 = wr_count;
    drive(1'b1, TransNonseq, 1'b1, 32'h43, HSIZE_BYTE);
    step();
    bus.HWDATA = 32'h55000000;
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, (r == 0) ? TransNonseq : TransSeq, 1'b0, 32'h40, HSIZE_WORD);
      #1;
      n_cmp++;
      if (ram_wen !== 4'b0000) begin
        n_err++; $display("FAIL b2b_nowrite%0d: got wen=%b want 0000", r, ram_wen);
      end
      if (r > 0) begin
        n_cmp++;
        if (bus.HRDATA !== 32'h55000000) begin
          n_err++; $display("FAIL b2b_merge%0d: got %h want 55000000", r, bus.HRDATA);
        end
      end
      step();
      bus.HWDATA = 32'h0;
    end
    drive_idle();
    #1;
    n_cmp++;
    if (bus.HRDATA !== 32'h55000000) begin
      n_err++; $display("FAIL b2b_merge_last: got %h want 55000000", bus.HRDATA);
    end
    n_cmp++;
    if (ram_wen !== 4'b1000 || ram_a !== 13'h10 || ram_d[31:24] !== 8'h55) begin
      n_err++; $display("FAIL b2b_drain: got wen=%b a=%h d=%h want 1000/010/55xxxxxx",
                        ram_wen, ram_a, ram_d);
    end
    n_cmp++;
    if (wr_count !== w0) begin
      n_err++; $display("FAIL b2b_early_write: got %0d writes want 0", wr_count - w0);
    end
    step();
    n_cmp++;
    if (mem[16] !== 32'h55000000) begin
      n_err++; $display("FAIL b2b_mem: got %h want 55000000", mem[16]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    preload(13'd20, 32'h12345678);
    w0 = wr_count;
    drive(1'b1, TransNonseq, 1'b1, 32'h50, HSIZE_WORD);
    step();
    drive(1'b1, TransNonseq, 1'b0, 32'h60, HSIZE_WORD);
    bus.HWDATA = 32'hFFFFFFFF;
    step();
    drive_idle();
    HRESETn = 1'b0;
    #1;
    n_cmp++;
    if (ram_wen !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_wen: got %b want 0000", ram_wen);
    end
    step();
    HRESETn = 1'b1;
    drive(1'b1, TransNonseq, 1'b0, 32'h50, HSIZE_WORD);
    step();
    drive_idle();
    #1;
    n_cmp++;
    if (ram_wen !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_drain: got %b want 0000", ram_wen);
    end
    n_cmp++;
    if (bus.HRDATA !== 32'h12345678) begin
      n_err++; $display("FAIL rst_mid_read: got %h want 12345678", bus.HRDATA);
    end
    step();
    n_cmp++;
    if (wr_count !== w0 || mem[20] !== 32'h12345678) begin
      n_err++; $display("FAIL rst_mid_mem: got %0d writes mem=%h want 0/12345678",
                        wr_count - w0, mem[20]);
    end
  endtask

  task automatic test_no_accept();
    drive(1'b1, TransBusy, 1'b1, 32'h80, HSIZE_WORD);
    step();
    drive(1'b1, TransNonseq, 1'b1, 32'h80, HSIZE_WORD);
    bus.HREADY = 1'b0;
    bus.HWDATA = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (ram_cen !== 1'b0) begin
      n_err++; $display("FAIL busy_write: got cen=%b want 0", ram_cen);
    end
    step();
    drive(1'b0, TransNonseq, 1'b1, 32'h80, HSIZE_WORD);
    #1;
    n_cmp++;
    if (ram_cen !== 1'b0) begin
      n_err++; $display("FAIL hready_low_write: got cen=%b want 0", ram_cen);
    end
    step();
    drive_idle();
    #1;
    n_cmp++;
    if (ram_cen !== 1'b0) begin
      n_err++; $display("FAIL unselected_write: got cen=%b want 0", ram_cen);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_word_write();
    test_partial_write();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_no_accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sram_bridge.md
# ahb_sram_bridge

AHB-Lite slave front end that drives the single-port 32-bit SRAM macro (registered read data, per-byte write enables) and returns its read data to the bus. A one-entry write buffer absorbs the AHB address/data phase skew, so every transfer completes with zero wait states. Sits between the AHB interconnect and the SRAM instance in the memory subsystem.

## Interface
- ADDR_W, 13: SRAM word-address width; the bus byte address uses HADDR[ADDR_W+1:0].
- HCLK  in  1  clock for the bridge and the SRAM
- HRESETn  in  1  synchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half-word, 2 = word
- HREADY  in  1  bus ready
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data (data phase)
- HREADYOUT  out  1  always 1
- HRESP  out  1  always 0 (OKAY)
- ram_a  out  ADDR_W  SRAM word address
- ram_d  out  32  SRAM write data
- ram_cen  out  1  SRAM enable, active high
- ram_wen  out  4  SRAM byte write enables, active high, lane i = bits [8i+7:8i]
- ram_q  in  32  SRAM read data, valid one cycle after ram_a

## Operation
- Accept: `acc = HSEL & HREADY & HTRANS[1]`.
  - A read address phase is `acc & ~HWRITE`.
  - A write address phase is `acc & HWRITE`.
- On write accept, register the word address and the lane mask in a data-phase register `dp_*`.
  - Lane mask: byte = 1 << HADDR[1:0]; half = 4'b0011 << {HADDR[1],1'b0}; word = 4'b1111.
  - HSIZE > 2 is treated as word.
- Write buffer `wb_{valid,addr,lanes,data}` holds one entry. Invariant: the buffer and a data-phase write never coexist.
- SRAM port arbitration, every cycle, in priority order:
  1. Read address phase: ram_a = HADDR word, ram_cen = 1, ram_wen = 0. A concurrent data-phase write is captured into wb (addr, lanes, HWDATA).
  2. Else if wb_valid: drain. ram_a = wb_addr, ram_d = wb_data, ram_wen = wb_lanes, ram_cen = 1. Clear wb_valid.
  3. Else if a data-phase write is in flight: write directly with ram_d = HWDATA and ram_wen = dp_lanes.
  4. Else: ram_cen = 0, ram_wen = 0.
- On read accept, register rd_pend = 1 and rd_addr.
- Read data phase:
  - Hit: `hit = rd_pend & wb_valid & (wb_addr == rd_addr)`.
  - HRDATA byte i = (hit & wb_lanes[i]) ? wb_data byte i : ram_q byte i.
  - With rd_pend = 0, HRDATA = ram_q (don't-care to the bus).
- ram_d is don't-care whenever ram_wen = 0.
- IDLE, BUSY, or HSEL = 0 transfers cause no SRAM write and no buffer change. An HREADY-low cycle is not an accept.

## Timing
- Reset: wb_valid = 0, dp write flag = 0, rd_pend = 0, ram_cen = 0, ram_wen = 0. HREADYOUT = 1 and HRESP = 0 at all times.
- Reset mid-operation: a buffered or data-phase write is discarded and never reaches the SRAM.
- Read latency: address phase in cycle N, HRDATA valid in cycle N+1 with no wait states.
- Write timing:
  - Address phase in cycle N, data in cycle N+1.
  - The SRAM is updated at the end of N+1 (direct path), or at the end of the first later cycle without a read address phase (buffered path).
- Back-to-back write then read: the write is buffered. The read to the same word returns merged data in its data phase.
- A continuous read stream holds the buffer indefinitely. This is legal; all read-after-write hazards are covered by the merge.
- Write then write: the second write's address phase has no read, so any buffered entry drains in that cycle. The invariant holds.
- Consecutive read data phases each merge against the current wb contents. wb does not change while reads are being issued.

## Structure
- Shared package `ahb_pkg`: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP_OKAY.
- Lane-mask generation is a function in `ahb_pkg`.
- One sub-module is natural: `sram_wbuf`, holding the write buffer register, the drain request, and the hit/merge mux. The arbiter stays in the top level.

## Test plan
- Reset, then word read of 0x0000_0010 with the SRAM preloaded with 0xDEADBEEF at word 4 → HRDATA = 0xDEADBEEF in the next cycle; HREADYOUT stays 1 throughout.
- Word write 0x11223344 to 0x20 followed by an idle → ram_wen = 4'hF, ram_a = 8, ram_d = 0x11223344 in the data-phase cycle.
- Byte write 0xAA to 0x21, then a half-word write 0xBBCC to 0x22, both onto word 0x11223344 → the word later reads 0xBBCCAA44.
- Word write 0xCAFEF00D to 0x40, immediately followed by a read of 0x40 → HRDATA = 0xCAFEF00D. The SRAM write occurs the cycle after the read address phase.
- Byte write 0x55 to 0x43 over 0x00000000, followed by four back-to-back reads of 0x40 → every HRDATA = 0x55000000 and no SRAM write occurs until the reads stop; the drain then has ram_wen = 4'b1000.
- Buffered write pending, then HRESETn low for one cycle → no SRAM write occurs; a subsequent read returns the old contents.
